// File: rtl/pixel_pack_pkg.sv
// Shared types and sizing helpers for the pixel group packer.
package pixel_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_e;

  // Width needed to hold a lane count of 0..n inclusive.
  function automatic int lane_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of a lane index 0..n-1.
  function automatic int lane_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pack_out_slot.sv
// Output register for one packed group: loads a group, holds it while
// downstream stalls, and drops valid once it has been taken.
module pack_out_slot #(
  parameter int GW = 64,
  parameter int CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [GW-1:0] i_load_data,
  input  logic [CW-1:0] i_load_count,
  input  logic          i_load_last,
  input  logic          i_ready,
  output logic          o_slot_free,
  output logic [GW-1:0] o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count,
  output logic          o_last
);

  logic [GW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_q, last_d;

  assign o_slot_free = !valid_q | i_ready;

  // A load is only issued while the slot is free, so it takes priority over drain.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    last_d  = last_q;
    if (i_load) begin
      data_d  = i_load_data;
      valid_d = 1'b1;
      count_d = i_load_count;
      last_d  = i_load_last;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_count = count_q;
  assign o_last  = last_q;

endmodule

// File: rtl/pixel_group_packer.sv
// Packs a serial pixel stream into groups of P_DATA_NUM lanes (lane 0 = first pixel).
// Optional PACK_FLUSH_EN: i_last closes a partial group with zeroed upper lanes.
module pixel_group_packer
  import pixel_pack_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_DATA_NUM   = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [P_DATA_WIDTH-1:0]              i_data,
  input  logic                                 i_valid,
  input  logic                                 i_last,
  output logic                                 o_ready,
  output logic [P_DATA_WIDTH*P_DATA_NUM-1:0]   o_data,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [$clog2(P_DATA_NUM+1)-1:0]      o_count,
  output logic                                 o_last,
  output state_e                               o_state
);

  localparam int W  = P_DATA_WIDTH;
  localparam int N  = P_DATA_NUM;
  localparam int GW = W * N;
  localparam int CW = lane_cnt_width(N);
  localparam int IW = lane_idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Handshake: a beat transfers on a cycle where valid and ready are both high
  // at the rising edge; valid never waits on ready, and held data must stay stable.

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] fill_q, fill_d;
  logic [CW-1:0] pend_count_q, pend_count_d;
  logic          pend_last_q, pend_last_d;

  logic          in_fire, out_fire, slot_free, closing, close_last;
  logic [GW-1:0] new_fill;
  logic [CW-1:0] close_count;
  logic          load, load_last;
  logic [GW-1:0] load_data;
  logic [CW-1:0] load_count;

  assign o_ready  = (state_q == FILL);
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

`ifdef PACK_FLUSH_EN
  assign close_last = i_last;
`else
  logic unused_last;
  assign unused_last = i_last;
  assign close_last  = 1'b0;
`endif

  assign closing     = in_fire & ((cnt_q == LAST_IDX) | close_last);
  assign close_count = CW'(cnt_q) + CW'(1);

  always_comb begin
    new_fill = fill_q;
    new_fill[cnt_q*W +: W] = i_data;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    pend_count_d = pend_count_q;
    pend_last_d  = pend_last_q;
    load         = 1'b0;
    load_data    = new_fill;
    load_count   = close_count;
    load_last    = close_last;
    case (state_q)
      FILL: begin
        if (in_fire) begin
          fill_d = new_fill;
          cnt_d  = cnt_q + IW'(1);
          if (closing) begin
            if (slot_free) begin
              load   = 1'b1;
              cnt_d  = '0;
              fill_d = '0;
            end else begin
              // Group parked in the fill buffer; counter stays at the closing lane.
              state_d      = PEND;
              cnt_d        = cnt_q;
              pend_count_d = close_count;
              pend_last_d  = close_last;
            end
          end
        end
      end
      PEND: begin
        load_data  = fill_q;
        load_count = pend_count_q;
        load_last  = pend_last_q;
        if (out_fire) begin
          load    = 1'b1;
          cnt_d   = '0;
          fill_d  = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      fill_q       <= '0;
      pend_count_q <= '0;
      pend_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      pend_count_q <= pend_count_d;
      pend_last_q  <= pend_last_d;
    end
  end

  pack_out_slot #(
    .GW (GW),
    .CW (CW)
  ) u_slot (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (load),
    .i_load_data  (load_data),
    .i_load_count (load_count),
    .i_load_last  (load_last),
    .i_ready      (i_ready),
    .o_slot_free  (slot_free),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_count      (o_count),
    .o_last       (o_last)
  );

  assign o_state = state_q;

endmodule

// File: tb/tb_pixel_group_packer.sv
// Self-checking bench for pixel_group_packer (W=8, N=8); flush cases under PACK_FLUSH_EN.
module tb_pixel_group_packer;
  import pixel_pack_pkg::*;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int GW = W * N;
  localparam int CW = $clog2(N + 1);
`ifdef PACK_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_last = 1'b0;
  logic          o_ready;
  logic [GW-1:0] o_data;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [CW-1:0] o_count;
  logic          o_last;
  state_e        o_state;

  int checks = 0;
  int errors = 0;

  // Reference model: accepted pixels of the open group, and completed groups
  // in delivery order (front = group currently presented on the output).
  logic [W-1:0]  pix_q[$];
  logic [GW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  logic          exp_last_q[$];

  always #5 clk = ~clk;

  pixel_group_packer #(
    .P_DATA_WIDTH (W),
    .P_DATA_NUM   (N)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_count (o_count),
    .o_last  (o_last),
    .o_state (o_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic close_group(input bit by_last);
    logic [GW-1:0] w;
    w = '0;
    for (int k = 0; k < pix_q.size(); k++) w[k*W +: W] = pix_q[k];
    exp_q.push_back(w);
    exp_cnt_q.push_back(CW'(pix_q.size()));
    exp_last_q.push_back(by_last);
    pix_q.delete();
  endtask

  // One clock: check outputs at the falling edge, advance the model, return
  // whether a pixel was accepted at the following rising edge.
  task automatic cycle(output bit acc);
    bit exp_rdy, exp_vld;
    @(negedge clk);
    exp_rdy = (exp_q.size() < 2);
    exp_vld = (exp_q.size() > 0);
    check("o_ready", o_ready, exp_rdy);
    check("o_valid", o_valid, exp_vld);
    if (exp_vld) begin
      check("o_data", o_data, exp_q[0]);
      check("o_count", o_count, exp_cnt_q[0]);
      check("o_last", o_last, exp_last_q[0]);
      if (i_ready) begin
        void'(exp_q.pop_front());
        void'(exp_cnt_q.pop_front());
        void'(exp_last_q.pop_front());
      end
    end
    acc = exp_rdy && i_valid;
    if (acc) begin
      pix_q.push_back(i_data);
      if (pix_q.size() == N || (FLUSH && i_last)) close_group(FLUSH && i_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input bit last, input bit rdy);
    bit acc;
    int n;
    i_data = d; i_last = last; i_valid = 1'b1; i_ready = rdy;
    n = 0;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) check("send_timeout", 1, 0);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic idle(input int cycles, input bit rdy);
    bit acc;
    i_valid = 1'b0; i_ready = rdy;
    for (int k = 0; k < cycles; k++) cycle(acc);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b0;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    pix_q.delete(); exp_q.delete(); exp_cnt_q.delete(); exp_last_q.delete();
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_count", o_count, 0);
    check("rst_o_last", o_last, 0);
    check("rst_o_ready", o_ready, 1);
    check("rst_state", o_state, FILL);
  endtask

  initial begin
    bit acc;
    int accepted, guard;

    repeat (2) @(posedge clk);
    do_reset();

    // Full-throughput streaming: two groups, ready never drops.
    for (int p = 1; p <= 16; p++) send(W'(p), 1'b0, 1'b1);
    idle(3, 1'b1);
    check("stream_drained", exp_q.size(), 0);

    // Downstream stalled: group0 held, group1 parks, ready drops.
    for (int p = 1; p <= 16; p++) send(W'(p), 1'b0, 1'b0);
    check("stall_o_ready", o_ready, 0);
    check("stall_state", o_state, PEND);
    check("stall_hold_data", o_data, 64'h0807060504030201);
    idle(2, 1'b0);
    idle(1, 1'b1);
    check("pend_xfer_data", o_data, 64'h100f0e0d0c0b0a09);
    check("pend_xfer_ready", o_ready, 1);
    check("pend_xfer_valid", o_valid, 1);
    idle(3, 1'b1);

    // Random valid/ready/last with random data.
    accepted = 0; guard = 0;
    while (accepted < 1000 && guard < 20000) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      i_last  = ($urandom_range(0, 7) == 0);
      i_data  = W'($urandom);
      cycle(acc);
      if (acc) accepted++;
      guard++;
    end
    if (accepted < 1000) check("random_timeout", accepted, 1000);
    idle(4, 1'b1);
    check("random_drained", exp_q.size(), 0);

    // Reset mid-group, then reset while parked.
    for (int p = 1; p <= 4; p++) send(W'(8'h40 + p), 1'b0, 1'b0);
    do_reset();
    for (int p = 1; p <= 16; p++) send(W'(8'h60 + p), 1'b0, 1'b0);
    check("pre_rst_state", o_state, PEND);
    do_reset();
    for (int p = 0; p < 8; p++) send(W'(8'hA0 + p), 1'b0, 1'b0);
    idle(1, 1'b0);
    check("post_rst_group", o_data, 64'hA7A6A5A4A3A2A1A0);
    idle(2, 1'b1);
    do_reset();

`ifdef PACK_FLUSH_EN
    send(8'd5, 1'b0, 1'b0);
    send(8'd6, 1'b0, 1'b0);
    send(8'd7, 1'b1, 1'b0);
    idle(1, 1'b0);
    check("flush_data", o_data, 64'h0000000000070605);
    check("flush_count", o_count, 3);
    check("flush_last", o_last, 1);
    idle(1, 1'b1);
    for (int p = 1; p <= 8; p++) send(W'(8'h10 + p), (p == 8), 1'b0);
    idle(1, 1'b0);
    check("flush_next_data", o_data, 64'h1817161514131211);
    check("flush_next_count", o_count, 8);
    check("flush_next_last", o_last, 1);
    idle(2, 1'b1);
`else
    for (int p = 1; p <= 8; p++) send(W'(p), 1'($urandom_range(0, 1)), 1'b0);
    idle(1, 1'b0);
    check("nolast_data", o_data, 64'h0807060504030201);
    check("nolast_count", o_count, 8);
    check("nolast_last", o_last, 0);
    idle(2, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
